// File: rtl/universal_shift_reg_pkg.sv
// Shared types for the universal shift register: the per-cycle operation code.
package universal_shift_reg_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_t;

endpackage

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: a 4:1 mux selecting hold, the
// more-significant neighbour (shift right), the less-significant neighbour
// (shift left) or parallel data, feeding a flip-flop with clear and enable.
module usr_bit_cell
   import universal_shift_reg_pkg::*;
(
   input  logic  clk,
   input  logic  rstn,
   input  logic  clr,
   input  logic  en,
   input  mode_t mode,
   input  logic  from_hi,
   input  logic  from_lo,
   input  logic  d,
   output logic  q
);

   logic q_nxt;

   // Mode mux: selects the value this bit takes on an enabled edge.
   always_comb begin
      q_nxt = q;
      case (mode)
         MODE_SHR:  q_nxt = from_hi;
         MODE_SHL:  q_nxt = from_lo;
         MODE_LOAD: q_nxt = d;
         default:   q_nxt = q;
      endcase
   end

   // Storage flop: async reset, then synchronous clear, then enable.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         q <= 1'b0;
      end else if (clr) begin
         q <= 1'b0;
      end else if (en) begin
         q <= q_nxt;
      end
   end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: WIDTH bit cells plus a saturating shift counter
// that flags when a loaded word has been fully shifted out.
module universal_shift_reg
   import universal_shift_reg_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int ROTATE = 0
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       clr,
   input  logic                       en,
   input  logic [1:0]                 mode,
   input  logic                       sir,
   input  logic                       sil,
   input  logic [WIDTH-1:0]           d,
   output logic [WIDTH-1:0]           q,
   output logic                       so_r,
   output logic                       so_l,
   output logic [$clog2(WIDTH+1)-1:0] cnt,
   output logic                       done
);

   localparam int CW = $clog2(WIDTH+1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

   mode_t            mode_e;
   logic [WIDTH-1:0] hi_in;
   logic [WIDTH-1:0] lo_in;

   assign mode_e = mode_t'(mode);

   // Neighbour wiring: end cells take the serial input or the rotate wrap.
   always_comb begin
      hi_in = {((ROTATE != 0) ? q[0] : sir), q[WIDTH-1:1]};
      lo_in = {q[WIDTH-2:0], ((ROTATE != 0) ? q[WIDTH-1] : sil)};
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      usr_bit_cell u_cell (
         .clk     (clk),
         .rstn    (rstn),
         .clr     (clr),
         .en      (en),
         .mode    (mode_e),
         .from_hi (hi_in[i]),
         .from_lo (lo_in[i]),
         .d       (d[i]),
         .q       (q[i])
      );
   end

   // Shift counter: restarts on load/clear, saturates at WIDTH while shifting.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         case (mode_e)
            MODE_LOAD: cnt <= '0;
            MODE_SHR, MODE_SHL: begin
               if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: cnt <= cnt;
         endcase
      end
   end

   // Output decodes of registered state only.
   always_comb begin
      so_r = q[0];
      so_l = q[WIDTH-1];
      done = (cnt == CNT_MAX);
   end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg at WIDTH=4, one instance per ROTATE setting.
module tb_universal_shift_reg;

   localparam int W  = 4;
   localparam int CW = $clog2(W+1);

   logic         clk = 1'b0;
   logic         rstn, clr, en, sir, sil;
   logic [1:0]   mode;
   logic [W-1:0] d;

   logic [W-1:0]  q_s, q_r;
   logic          so_r_s, so_l_s, done_s;
   logic          so_r_r, so_l_r, done_r;
   logic [CW-1:0] cnt_s, cnt_r;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   universal_shift_reg #(.WIDTH(W), .ROTATE(0)) u_dut (
      .clk(clk), .rstn(rstn), .clr(clr), .en(en), .mode(mode),
      .sir(sir), .sil(sil), .d(d),
      .q(q_s), .so_r(so_r_s), .so_l(so_l_s), .cnt(cnt_s), .done(done_s)
   );

   universal_shift_reg #(.WIDTH(W), .ROTATE(1)) u_rot (
      .clk(clk), .rstn(rstn), .clr(clr), .en(en), .mode(mode),
      .sir(sir), .sil(sil), .d(d),
      .q(q_r), .so_r(so_r_r), .so_l(so_l_r), .cnt(cnt_r), .done(done_r)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0] shr_q   [5] = '{4'b1101, 4'b1110, 4'b1111, 4'b1111, 4'b1111};
      logic         shr_so  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [CW-1:0] shr_c  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      logic [W-1:0] shl_q   [3] = '{4'b0110, 4'b1100, 4'b1000};
      logic         shl_so  [3] = '{1'b0, 1'b0, 1'b1};
      logic [W-1:0] sat_q   [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b0000};

      rstn = 1'b0; clr = 1'b0; en = 1'b0; mode = 2'b00;
      sir = 1'b0; sil = 1'b0; d = '0;
      #2;
      check("reset_q",    32'(q_s),    32'd0);
      check("reset_cnt",  32'(cnt_s),  32'd0);
      check("reset_done", 32'(done_s), 32'd0);
      check("reset_q_rot", 32'(q_r),   32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Load, then async reset between edges
      en = 1'b1; mode = 2'b11; d = 4'b1011;
      tick();
      check("load_1011", 32'(q_s), 32'b1011);
      #2;
      rstn = 1'b0;
      #1;
      check("async_rst_q",    32'(q_s),    32'd0);
      check("async_rst_cnt",  32'(cnt_s),  32'd0);
      check("async_rst_done", 32'(done_s), 32'd0);
      @(negedge clk);
      rstn = 1'b1; en = 1'b0; mode = 2'b11; d = 4'b1011;
      tick();
      check("post_rst_en0_q", 32'(q_s), 32'd0);

      // Load 1010 and shift right x5 with sir=1
      en = 1'b1; mode = 2'b11; d = 4'b1010;
      tick();
      check("load_1010_q",   32'(q_s),   32'b1010);
      check("load_1010_cnt", 32'(cnt_s), 32'd0);
      mode = 2'b01; sir = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("shr_so_r[%0d]", i), 32'(so_r_s), 32'(shr_so[i]));
         tick();
         check($sformatf("shr_q[%0d]", i),    32'(q_s),    32'(shr_q[i]));
         check($sformatf("shr_cnt[%0d]", i),  32'(cnt_s),  32'(shr_c[i]));
         check($sformatf("shr_done[%0d]", i), 32'(done_s), (i >= 3) ? 32'd1 : 32'd0);
      end

      // Load 0011 and shift left x3 with sil=0
      mode = 2'b11; d = 4'b0011; sir = 1'b0;
      tick();
      check("load_0011", 32'(q_s), 32'b0011);
      mode = 2'b10; sil = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("shl_so_l[%0d]", i), 32'(so_l_s), 32'(shl_so[i]));
         tick();
         check($sformatf("shl_q[%0d]", i), 32'(q_s), 32'(shl_q[i]));
      end

      // Rotate vs. serial: load 1001, shift left x2, then right x1
      mode = 2'b11; d = 4'b1001;
      tick();
      check("rot_load", 32'(q_r), 32'b1001);
      mode = 2'b10; sil = 1'b0;
      tick();
      check("rot_shl1", 32'(q_r), 32'b0011);
      check("ser_shl1", 32'(q_s), 32'b0010);
      tick();
      check("rot_shl2", 32'(q_r), 32'b0110);
      check("ser_shl2", 32'(q_s), 32'b0100);
      mode = 2'b01; sir = 1'b1;
      tick();
      check("rot_shr1", 32'(q_r), 32'b0011);
      check("ser_shr1", 32'(q_s), 32'b1010);
      sir = 1'b0;

      // Enable low blocks a load; clear overrides en=0
      mode = 2'b11; d = 4'b0101;
      tick();
      check("load_0101", 32'(q_s), 32'b0101);
      en = 1'b0; d = 4'b1111;
      tick();
      check("en0_hold_q", 32'(q_s), 32'b0101);
      clr = 1'b1;
      tick();
      check("clr_en0_q",   32'(q_s),   32'd0);
      check("clr_en0_cnt", 32'(cnt_s), 32'd0);
      clr = 1'b0;

      // Clear wins over a simultaneous load, with a nonzero count
      en = 1'b1; mode = 2'b01; sir = 1'b1;
      tick();
      tick();
      check("pre_clr_q",   32'(q_s),   32'b1100);
      check("pre_clr_cnt", 32'(cnt_s), 32'd2);
      clr = 1'b1; mode = 2'b11; d = 4'b1111;
      tick();
      check("clr_vs_load_q",   32'(q_s),   32'd0);
      check("clr_vs_load_cnt", 32'(cnt_s), 32'd0);
      clr = 1'b0;

      // Shift x4 from a load, then reload: done falls on the load edge
      mode = 2'b11; d = 4'b1001; sir = 1'b0;
      tick();
      mode = 2'b01;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("sat_done_pre[%0d]", i), 32'(done_s), 32'd0);
         tick();
         check($sformatf("sat_q[%0d]", i), 32'(q_s), 32'(sat_q[i]));
      end
      check("sat_cnt",  32'(cnt_s),  32'd4);
      check("sat_done", 32'(done_s), 32'd1);
      mode = 2'b11; d = 4'b0110;
      tick();
      check("reload_q",    32'(q_s),    32'b0110);
      check("reload_cnt",  32'(cnt_s),  32'd0);
      check("reload_done", 32'(done_s), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
